// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC datapath: field width, prime, arbiter
// state encoding and arbiter parameter defaults.
package ecc_pkg;

    localparam int FIELD_W = 256;

    // secp256k1 field prime: 2^256 - 2^32 - 977
    localparam logic [FIELD_W-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    localparam int NREQ_DEFAULT    = 4;
    localparam int TIMEOUT_DEFAULT = 2048;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first requester with its
// bit set, searching upward (with wrap) from the index after last_grant.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [IW-1:0]   grant,
    output logic            any
);

    // Walk from the farthest candidate to the nearest so the nearest hit wins
    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        idx   = 0;
        grant = last_grant;
        any   = 1'b0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NREQ;
            if (req[idx]) begin
                grant = IW'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_mul_arbiter.sv
// Shares one external mod_mul between NREQ requesters. A request is granted
// round-robin in IDLE, issued with a one-cycle start pulse, awaited with a
// timeout, and answered with a one-hot, one-cycle response strobe.
module mod_mul_arbiter
    import ecc_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*FIELD_W-1:0] req_a,
    input  logic [NREQ*FIELD_W-1:0] req_b,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [FIELD_W-1:0]      rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    mm_start,
    output logic [FIELD_W-1:0]      mm_a,
    output logic [FIELD_W-1:0]      mm_b,
    input  logic [FIELD_W-1:0]      mm_result,
    input  logic                    mm_done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t    state, state_next;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] last_grant_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          timeout_hit;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick_idx),
        .any        (pick_any)
    );

    assign timeout_hit = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the clock edge.
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; mm_done is looked at only in WAIT and beats the timeout
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (pick_any) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (mm_done || timeout_hit) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded directly from the state
    always_comb begin
        rsp_valid = '0;
        if (state == ST_RESP) rsp_valid[grant_q] = 1'b1;
        mm_start = (state == ST_ISSUE);
        busy     = (state != ST_IDLE);
    end

    // Datapath: operand capture, timeout counter, response and grant history
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the wide operand/result registers are reset too, because the
        // block must present all-zero outputs while reset is held.
        if (rst) begin
            grant_q      <= LAST_RST;
            last_grant_q <= LAST_RST;
            cnt_q        <= '0;
            mm_a         <= '0;
            mm_b         <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        mm_a    <= req_a[int'(pick_idx)*FIELD_W +: FIELD_W];
                        mm_b    <= req_b[int'(pick_idx)*FIELD_W +: FIELD_W];
                    end
                end
                ST_ISSUE: cnt_q <= '0;
                ST_WAIT: begin
                    if (mm_done) begin
                        rsp_data <= mm_result;
                        rsp_err  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (timeout_hit) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                ST_RESP: last_grant_q <= grant_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul_arbiter.sv
// Self-checking bench for mod_mul_arbiter with a behavioural mod_mul stub.
module tb_mod_mul_arbiter;
    import ecc_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*FIELD_W-1:0] req_a, req_b;
    logic [NREQ-1:0]         rsp_valid;
    logic [FIELD_W-1:0]      rsp_data;
    logic                    rsp_err, busy, mm_start;
    logic [FIELD_W-1:0]      mm_a, mm_b, mm_result;
    logic                    mm_done;

    int checks = 0;
    int errors = 0;

    mod_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] prod, r;
        prod = {256'd0, a} * {256'd0, b};
        r    = prod % {256'd0, P};
        return r[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference round-robin rule: first set bit after last, with wrap
    function automatic int rr_model(input logic [NREQ-1:0] mask, input int last);
        for (int off = 1; off <= NREQ; off++)
            if (mask[(last + off) % NREQ]) return (last + off) % NREQ;
        return -1;
    endfunction

    // mod_mul stub: done idles high, drops on start, rises stub_lat cycles later
    int           stub_lat = 3;
    bit           stub_stall = 0;
    int           stub_cnt;
    logic [255:0] stub_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_done   <= 1'b1;
            mm_result <= '0;
            stub_cnt  <= 0;
        end else if (mm_start) begin
            mm_done  <= 1'b0;
            stub_cnt <= stub_lat;
            stub_res <= mulmod(mm_a, mm_b);
        end else if (!mm_done && !stub_stall) begin
            if (stub_cnt <= 1) begin
                mm_done   <= 1'b1;
                mm_result <= stub_res;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    int cyc = 0;
    int starts = 0;
    int last_start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mm_start) begin
        starts         <= starts + 1;
        last_start_cyc <= cyc;
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic set_op(input int idx, input logic [255:0] a, input logic [255:0] b);
        req_a[idx*256 +: 256] = a;
        req_b[idx*256 +: 256] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for a response; drop the given req bits when it appears
    task automatic wait_rsp(input logic [NREQ-1:0] drop, output int gidx,
                            output logic [255:0] data, output logic err, output int delta);
        gidx = -1; data = '0; err = 1'b0; delta = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                check("rsp_onehot", 256'($onehot(rsp_valid)), 256'd1);
                for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) gidx = i;
                data  = rsp_data;
                err   = rsp_err;
                delta = cyc - last_start_cyc;
                req   = req & ~drop;
                return;
            end
        end
        check("rsp_timeout", 256'd0, 256'd1);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (mm_start) begin ok = 1'b1; return; end
        end
        check("start_timeout", 256'd0, 256'd1);
    endtask

    typedef struct {
        int           idx;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] exp;
    } vec_t;

    vec_t         vecs [5];
    int           gidx, delta, last, exp_idx, prev;
    logic [255:0] data, exp_data;
    logic         err;
    logic [255:0] ops_a [NREQ];
    logic [255:0] ops_b [NREQ];
    logic [NREQ-1:0] mask;
    bit           ok;
    int           s0, vcount;

    initial begin
        vecs[0] = '{idx: 0, a: 256'd2,     b: 256'd3,     exp: 256'd6};
        vecs[1] = '{idx: 2, a: P - 256'd1, b: P - 256'd1, exp: 256'd1};
        vecs[2] = '{idx: 1, a: 256'd0,     b: 256'd5,     exp: 256'd0};
        vecs[3] = '{idx: 3, a: P - 256'd1, b: 256'd2,     exp: P - 256'd2};
        vecs[4] = '{idx: 1, a: 256'd1 << 255, b: 256'd2,  exp: 256'h1_0000_03D1};

        rst = 1'b0; req = '0; req_a = '0; req_b = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_rsp_valid", 256'(rsp_valid), 256'd0);
        check("rst_rsp_data", rsp_data, 256'd0);
        check("rst_rsp_err", 256'(rsp_err), 256'd0);
        check("rst_mm_start", 256'(mm_start), 256'd0);
        check("rst_mm_a", mm_a, 256'd0);
        check("rst_mm_b", mm_b, 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table of single-requester operations with hand-computed results
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1;
            set_op(vecs[v].idx, vecs[v].a, vecs[v].b);
            req = NREQ'(1) << vecs[v].idx;
            s0  = starts;
            wait_rsp('1, gidx, data, err, delta);
            check("vec_grant", 256'(gidx), 256'(vecs[v].idx));
            check("vec_data", data, vecs[v].exp);
            check("vec_err", 256'(err), 256'd0);
            check("vec_starts", 256'(starts - s0), 256'd1);
            check("vec_latency", 256'(delta), 256'(stub_lat + 2));
        end

        // Random operands and mod_mul latencies
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            stub_lat = $urandom_range(1, 8);
            exp_idx  = $urandom_range(0, NREQ - 1);
            ops_a[0] = ($urandom_range(0, 3) == 0) ? P - 256'($urandom_range(1, 9)) : rand256() % P;
            ops_b[0] = rand256() % P;
            set_op(exp_idx, ops_a[0], ops_b[0]);
            req = NREQ'(1) << exp_idx;
            wait_rsp('1, gidx, data, err, delta);
            check("rnd_grant", 256'(gidx), 256'(exp_idx));
            check("rnd_data", data, mulmod(ops_a[0], ops_b[0]));
            check("rnd_err", 256'(err), 256'd0);
            check("rnd_latency", 256'(delta), 256'(stub_lat + 2));
        end
        stub_lat = 3;

        // All four requesting from reset: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            ops_a[i] = rand256() % P;
            ops_b[i] = rand256() % P;
            set_op(i, ops_a[i], ops_b[i]);
        end
        @(posedge clk); #1;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_rsp((g == 4) ? 4'b1111 : 4'b0000, gidx, data, err, delta);
            check("rr_all_grant", 256'(gidx), 256'(g % NREQ));
            if (gidx >= 0) check("rr_all_data", data, mulmod(ops_a[gidx], ops_b[gidx]));
        end

        // Requesters 0 and 2 held: 0,2,0,2 with no back-to-back 0
        do_reset();
        @(posedge clk); #1;
        req  = 4'b0101;
        prev = -1;
        for (int g = 0; g < 4; g++) begin
            wait_rsp((g == 3) ? 4'b1111 : 4'b0000, gidx, data, err, delta);
            check("rr_02_grant", 256'(gidx), 256'((g % 2) * 2));
            check("rr_02_no_repeat0", 256'(prev == 0 && gidx == 0), 256'd0);
            prev = gidx;
        end

        // Random held masks against the round-robin rule
        last = 2;
        for (int burst = 0; burst < 6; burst++) begin
            @(posedge clk); #1;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req  = mask;
            for (int g = 0; g < 4; g++) begin
                wait_rsp((g == 3) ? 4'b1111 : 4'b0000, gidx, data, err, delta);
                exp_idx = rr_model(mask, last);
                check("rr_rnd_grant", 256'(gidx), 256'(exp_idx));
                last = exp_idx;
            end
        end

        // mm_done arriving in the same WAIT cycle as the timeout: done wins
        @(posedge clk); #1;
        stub_lat = TIMEOUT - 1;
        set_op(1, 256'd11, 256'd13);
        req = 4'b0010;
        wait_rsp('1, gidx, data, err, delta);
        check("tie_err", 256'(err), 256'd0);
        check("tie_data", data, 256'd143);
        check("tie_latency", 256'(delta), 256'(TIMEOUT + 1));

        // mm_done one cycle too late: timeout
        @(posedge clk); #1;
        stub_lat = TIMEOUT;
        req = 4'b0010;
        wait_rsp('1, gidx, data, err, delta);
        check("late_err", 256'(err), 256'd1);
        check("late_data", data, 256'd0);

        // mm_done never rises: error response after 16 WAIT cycles
        repeat (TIMEOUT + 4) @(posedge clk);
        #1;
        stub_stall = 1'b1;
        req = 4'b0100;
        wait_rsp('1, gidx, data, err, delta);
        check("to_grant", 256'(gidx), 256'd2);
        check("to_err", 256'(err), 256'd1);
        check("to_data", data, 256'd0);
        check("to_latency", 256'(delta), 256'(TIMEOUT + 1));
        stub_stall = 1'b0;
        stub_lat   = 4;
        do_reset();

        // Dropping req and changing operands after grant does not matter
        @(posedge clk); #1;
        set_op(3, 256'd7, 256'd9);
        req = 4'b1000;
        wait_start(ok);
        req = '0;
        set_op(3, 256'd100, 256'd100);
        wait_rsp('1, gidx, data, err, delta);
        check("drop_grant", 256'(gidx), 256'd3);
        check("drop_data", data, 256'd63);

        // Reset in the middle of WAIT drops the operation and restores priority
        @(posedge clk); #1;
        set_op(0, 256'd5, 256'd5);
        req = 4'b0001;
        wait_rsp('1, gidx, data, err, delta);
        @(posedge clk); #1;
        stub_lat = 8;
        set_op(2, 256'd3, 256'd4);
        req = 4'b0100;
        wait_start(ok);
        repeat (2) @(negedge clk);
        check("mid_busy", 256'(busy), 256'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rsp_valid", 256'(rsp_valid), 256'd0);
        check("mid_rsp_data", rsp_data, 256'd0);
        check("mid_rsp_err", 256'(rsp_err), 256'd0);
        check("mid_mm_start", 256'(mm_start), 256'd0);
        check("mid_mm_a", mm_a, 256'd0);
        check("mid_mm_b", mm_b, 256'd0);
        check("mid_busy_rst", 256'(busy), 256'd0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rsp_valid != '0) vcount++;
        end
        check("mid_no_rsp", 256'(vcount), 256'd0);
        @(posedge clk); #1;
        req = 4'b1111;
        wait_rsp('1, gidx, data, err, delta);
        check("mid_first_grant", 256'(gidx), 256'd0);
        check("mid_first_data", data, 256'd25);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_mul_arbiter.md
MOD_MUL_ARBITER -- requirements
Module: mod_mul_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one mod_mul instance.
REQ-002 SHALL have parameter TIMEOUT, default 2048, maximum WAIT cycles before an error response.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port req, input, NREQ, per-requester operation request (level).
REQ-006 SHALL have port req_a, input, NREQ*256, packed operand A; slice i belongs to requester i.
REQ-007 SHALL have port req_b, input, NREQ*256, packed operand B; slice i belongs to requester i.
REQ-008 SHALL have port rsp_valid, output, NREQ, one-hot one-cycle response strobe.
REQ-009 SHALL have port rsp_data, output, 256, product mod P for the strobed requester.
REQ-010 SHALL have port rsp_err, output, 1, high with rsp_valid when the response is a timeout.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have ports mm_start (output, 1), mm_a (output, 256), mm_b (output, 256), mm_result (input, 256) and mm_done (input, 1), the connection to the external mod_mul.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT and RESP.
REQ-014 IDLE: when req is nonzero, SHALL pick a requester round-robin, starting from the index after last_grant, then latch its operands into mm_a/mm_b, record grant, and go to ISSUE.
REQ-015 IDLE: when req is zero, SHALL stay in IDLE.
REQ-016 ISSUE: SHALL drive mm_start high for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-017 WAIT: SHALL qualify mm_done only in this state, because mm_done stays high between operations.
REQ-018 WAIT: on mm_done high, SHALL latch mm_result into rsp_data, clear rsp_err, and go to RESP.
REQ-019 WAIT: SHALL increment the timeout counter every cycle that mm_done is low.
REQ-020 WAIT: when the counter reaches TIMEOUT-1 with mm_done low, SHALL set rsp_err, load rsp_data with 0, and go to RESP.
REQ-021 If mm_done and the timeout condition occur in the same cycle, mm_done SHALL win.
REQ-022 RESP: SHALL assert rsp_valid[grant] for one cycle, set last_grant to grant, and go to IDLE.
REQ-023 Handshake: a requester SHALL hold req and its operands until its rsp_valid.
REQ-024 Handshake: a requester's req SHALL be sampled only in IDLE, so req still high in the IDLE after RESP counts as a new request.
REQ-025 Deasserting req after grant SHALL NOT abort the operation; the response is still delivered.
REQ-026 Operands SHALL be captured only in IDLE; later changes to req_a/req_b SHALL be ignored.
REQ-027 Latency SHALL be: request seen in IDLE, then ISSUE next cycle, then rsp_valid one cycle after the WAIT cycle that sees mm_done.
REQ-028 Total latency SHALL be mod_mul latency plus 3 cycles.
REQ-029 Starvation SHALL be bounded: with all requests continuously asserted, every requester SHALL be served within NREQ grants.
REQ-030 last_grant SHALL reset to NREQ-1, so requester 0 has priority first after reset.

Reset
REQ-031 rst SHALL asynchronously force state IDLE.
REQ-032 rst SHALL asynchronously force rsp_valid=0, rsp_data=0, rsp_err=0, mm_start=0, mm_a=0, mm_b=0, busy=0, the timeout counter to 0, and last_grant=NREQ-1.
REQ-033 Reset during ISSUE, WAIT or RESP SHALL drop the operation with no response.
REQ-034 The system SHALL reset the external mod_mul with the same rst.

Structure
REQ-035 The shared package ecc_pkg SHALL hold the prime P, the 256-bit field width, the state enum, and the NREQ/TIMEOUT defaults.
REQ-036 The block SHALL instantiate one sub-module, rr_pick: a combinational round-robin selector (req, last_grant to grant index, any).
REQ-037 mod_mul SHALL NOT be instantiated inside this block; it is connected at the parent level.

Verification
REQ-038 Single request, req=0001, a=2, b=3: SHALL give rsp_valid=0001, rsp_data=6, rsp_err=0, with mm_start pulsed exactly once.
REQ-039 Operands P-1 and P-1 from requester 2: SHALL give rsp_data=1 on rsp_valid=0100.
REQ-040 req=1111 held from reset, each requester re-requesting after its response: grant order SHALL be 0,1,2,3,0.
REQ-041 req0 and req2 continuously high: grants SHALL alternate 0,2,0,2 and requester 0 SHALL never be served twice in a row.
REQ-042 Stub mod_mul with mm_done held low after start, TIMEOUT=16: SHALL give rsp_err=1, rsp_data=0, and rsp_valid exactly 16 WAIT cycles after ISSUE.
REQ-043 rst pulsed mid-WAIT: all outputs SHALL be 0 the same cycle, there SHALL be no rsp_valid for the dropped operation, and the next request SHALL go to requester 0 first.
